regfile_write_arbiter: RTL and testbench

//  Shares the register bank's single write port (WE3/A3/WD3) between two writeback sources:
//  A = ALU/datapath writeback, B = multi-cycle/load return.

---
 rtl/regfile_write_arbiter.sv | 156 +++++++++++++++
 tb/tb_regfile_write_arbiter.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/regfile_write_arbiter.sv
// Two-source arbiter for the register bank write port: one holding slot per source,
// round-robin between sources, arrival order for same-register writes. Forwarding under WRF_FWD_EN.
module regfile_write_slot #(
  parameter int ADDR_W   = 4,
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 15
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              valid,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data,
  input  logic              gnt,
  output logic              ready,
  output logic              full,
  output logic              load,
  output logic              err,
  output logic [ADDR_W-1:0] s_addr,
  output logic [DATA_W-1:0] s_data
);
  localparam logic [ADDR_W:0] LIM = NUM_REGS[ADDR_W:0];

  logic acc, legal;

  assign ready = ~full | gnt;
  assign acc   = valid & ready;
  assign legal = {1'b0, addr} < LIM;
  assign load  = acc & legal;
  // out-of-range writes complete the handshake but are dropped here
  assign err   = acc & ~legal;

  always_ff @(posedge CLK) begin
    if (Reset) begin
      full   <= 1'b0;
      s_addr <= '0;
      s_data <= '0;
    end else if (load) begin
      full   <= 1'b1;
      s_addr <= addr;
      s_data <= data;
    end else if (gnt) begin
      full   <= 1'b0;
    end
  end
endmodule

module regfile_write_arbiter #(
  parameter int ADDR_W   = 4,
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 15
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              A_Valid,
  output logic              A_Ready,
  input  logic [ADDR_W-1:0] A_Addr,
  input  logic [DATA_W-1:0] A_Data,
  input  logic              B_Valid,
  output logic              B_Ready,
  input  logic [ADDR_W-1:0] B_Addr,
  input  logic [DATA_W-1:0] B_Data,
  output logic              WE3,
  output logic [ADDR_W-1:0] A3,
  output logic [DATA_W-1:0] WD3,
  output logic              ErrAddr,
  output logic              Busy,
  input  logic [ADDR_W-1:0] FwdAddr,
  output logic              FwdHit,
  output logic [DATA_W-1:0] FwdData
);
  localparam int NSRC = 2;
  localparam logic [ADDR_W:0] LIM = NUM_REGS[ADDR_W:0];

  logic [NSRC-1:0]             vld, rdy, full, gnt, load, err;
  logic [NSRC-1:0][ADDR_W-1:0] in_addr, s_addr;
  logic [NSRC-1:0][DATA_W-1:0] in_data, s_data;
  logic older_b;  // B's contents were loaded strictly before A's
  logic rr_b;     // round-robin pointer: 0 = A next, 1 = B next
  logic g, same, contend;

  assign vld     = {B_Valid, A_Valid};
  assign in_addr = {B_Addr, A_Addr};
  assign in_data = {B_Data, A_Data};
  assign A_Ready = rdy[0];
  assign B_Ready = rdy[1];

  generate
    for (genvar i = 0; i < NSRC; i++) begin : g_slot
      regfile_write_slot #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_REGS(NUM_REGS)) u_slot (
        .CLK(CLK), .Reset(Reset), .valid(vld[i]), .addr(in_addr[i]), .data(in_data[i]),
        .gnt(gnt[i]), .ready(rdy[i]), .full(full[i]), .load(load[i]), .err(err[i]),
        .s_addr(s_addr[i]), .s_data(s_data[i]));
    end
  endgenerate

  assign same    = s_addr[0] == s_addr[1];
  assign contend = &full & ~same;

  always_comb begin
    gnt = '0;
    case (full)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (same ? older_b : rr_b) ? 2'b10 : 2'b01;
      default: gnt = '0;
    endcase
  end

  assign g    = gnt[1];
  assign Busy = |full | WE3;

  always_ff @(posedge CLK) begin
    if (Reset) begin
      rr_b    <= 1'b0;
      older_b <= 1'b0;
      WE3     <= 1'b0;
      A3      <= '0;
      WD3     <= '0;
      ErrAddr <= 1'b0;
    end else begin
      if (contend) rr_b <= ~rr_b;
      // a B load (alone or tied with A) makes A the earlier one
      if (load[1])      older_b <= 1'b0;
      else if (load[0]) older_b <= 1'b1;
      WE3     <= |gnt;
      if (|gnt) begin
        A3  <= s_addr[g];
        WD3 <= s_data[g];
      end
      ErrAddr <= ErrAddr | (|err);
    end
  end

`ifdef WRF_FWD_EN
  logic [NSRC-1:0] fm;
  logic om, fwd_ok, nw;

  assign fwd_ok = {1'b0, FwdAddr} < LIM;
  assign nw     = ~older_b;  // newer slot when both are full

  always_comb begin
    for (int i = 0; i < NSRC; i++) fm[i] = full[i] & (s_addr[i] == FwdAddr) & fwd_ok;
    om      = WE3 & (A3 == FwdAddr) & fwd_ok;
    FwdHit  = |fm | om;
    FwdData = '0;
    if (fm[nw])       FwdData = s_data[nw];
    else if (fm[~nw]) FwdData = s_data[~nw];
    else if (om)      FwdData = WD3;
  end
`else
  logic unused_fwd;
  assign unused_fwd = ^FwdAddr;
  assign FwdHit     = 1'b0;
  assign FwdData    = '0;
`endif
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Randomized bench for regfile_write_arbiter against a sequence-number reference model.
module tb_regfile_write_arbiter;
  logic        CLK = 0, Reset = 1;
  logic        A_Valid = 0, B_Valid = 0, A_Ready, B_Ready;
  logic [3:0]  A_Addr = 0, B_Addr = 0, A3, FwdAddr = 0;
  logic [31:0] A_Data = 0, B_Data = 0, WD3, FwdData;
  logic        WE3, ErrAddr, Busy, FwdHit;

  regfile_write_arbiter dut (
    .CLK(CLK), .Reset(Reset),
    .A_Valid(A_Valid), .A_Ready(A_Ready), .A_Addr(A_Addr), .A_Data(A_Data),
    .B_Valid(B_Valid), .B_Ready(B_Ready), .B_Addr(B_Addr), .B_Data(B_Data),
    .WE3(WE3), .A3(A3), .WD3(WD3), .ErrAddr(ErrAddr), .Busy(Busy),
    .FwdAddr(FwdAddr), .FwdHit(FwdHit), .FwdData(FwdData));

  always #5 CLK = ~CLK;

  int nvec = 0, nerr = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // reference model: slots tagged with the edge number at which they were loaded
  bit          m_full[2];
  logic [3:0]  m_addr[2];
  logic [31:0] m_data[2];
  int          m_seq[2];
  int          edge_n;
  bit          m_rr, m_we, m_err;
  logic [3:0]  m_a3;
  logic [31:0] m_wd3;

  task automatic m_reset();
    for (int i = 0; i < 2; i++) begin m_full[i] = 0; m_addr[i] = 0; m_data[i] = 0; m_seq[i] = 0; end
    m_rr = 0; m_we = 0; m_err = 0; m_a3 = 0; m_wd3 = 0;
  endtask

  function automatic int m_grant();
    if (m_full[0] && !m_full[1]) return 0;
    if (m_full[1] && !m_full[0]) return 1;
    if (!m_full[0]) return -1;
    if (m_addr[0] == m_addr[1]) return (m_seq[1] < m_seq[0]) ? 1 : 0;
    return m_rr ? 1 : 0;
  endfunction

  task automatic cyc(input bit av, input logic [3:0] aa, input logic [31:0] ad,
                     input bit bv, input logic [3:0] ba, input logic [31:0] bd,
                     input logic [3:0] fa);
    int g, best;
    bit rdy[2], vv[2];
    logic [3:0]  va[2];
    logic [31:0] vd[2];
    bit fh;
    logic [31:0] fd;
    @(negedge CLK);
    A_Valid = av; A_Addr = aa; A_Data = ad;
    B_Valid = bv; B_Addr = ba; B_Data = bd; FwdAddr = fa;
    #1;
    g = m_grant();
    rdy[0] = !m_full[0] || g == 0;
    rdy[1] = !m_full[1] || g == 1;
    fh = 0; fd = 0; best = -1;
`ifdef WRF_FWD_EN
    if (fa < 15) begin
      for (int i = 0; i < 2; i++)
        if (m_full[i] && m_addr[i] == fa && (best < 0 || m_seq[i] >= m_seq[best])) best = i;
      if (best >= 0) begin fh = 1; fd = m_data[best]; end
      else if (m_we && m_a3 == fa) begin fh = 1; fd = m_wd3; end
    end
`endif
    chk("a_ready", A_Ready, rdy[0]);
    chk("b_ready", B_Ready, rdy[1]);
    chk("we3", WE3, m_we);
    chk("a3", A3, m_a3);
    chk("wd3", WD3, m_wd3);
    chk("err", ErrAddr, m_err);
    chk("busy", Busy, m_full[0] | m_full[1] | m_we);
    chk("fwdhit", FwdHit, fh);
    chk("fwddata", FwdData, fd);
    @(posedge CLK);
    vv[0] = av; va[0] = aa; vd[0] = ad;
    vv[1] = bv; va[1] = ba; vd[1] = bd;
    m_we = (g >= 0);
    if (g >= 0) begin
      m_a3 = m_addr[g]; m_wd3 = m_data[g];
      if (m_full[0] && m_full[1] && m_addr[0] != m_addr[1]) m_rr = (g == 0);
      m_full[g] = 0;
    end
    for (int i = 0; i < 2; i++)
      if (vv[i] && rdy[i]) begin
        if (va[i] < 15) begin
          m_full[i] = 1; m_addr[i] = va[i]; m_data[i] = vd[i]; m_seq[i] = edge_n;
        end else m_err = 1;
      end
    edge_n++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    Reset = 1; A_Valid = 1; A_Addr = 3; B_Valid = 1'($urandom); FwdAddr = 0;
    @(negedge CLK);
    @(negedge CLK);
    #1;
    chk("rst_we3", WE3, 0);
    chk("rst_a3", A3, 0);
    chk("rst_wd3", WD3, 0);
    chk("rst_aready", A_Ready, 1);
    chk("rst_err", ErrAddr, 0);
    chk("rst_busy", Busy, 0);
    chk("rst_fwdhit", FwdHit, 0);
    m_reset();
    Reset = 0; A_Valid = 0; B_Valid = 0;
  endtask

  function automatic logic [3:0] raddr();
    logic [3:0] t[5];
    t = '{4'd1, 4'd2, 4'd5, 4'd7, 4'd15};
    return ($urandom_range(0, 3) == 0) ? t[$urandom_range(0, 4)] : 4'($urandom_range(0, 15));
  endfunction

  initial begin
    edge_n = 0;
    do_reset();

    // single write
    cyc(1, 3, 32'hDEADBEEF, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    #2;
    chk("t2_we3", WE3, 1);
    chk("t2_a3", A3, 3);
    chk("t2_wd3", WD3, 32'hDEADBEEF);
    cyc(0, 0, 0, 0, 0, 0, 0);
    #2;
    chk("t2_we3_off", WE3, 0);
    chk("t2_busy", Busy, 0);

    // both sources saturating, different registers
    for (int i = 0; i < 8; i++) cyc(1, 1, 32'h11, 1, 2, 32'h22, 0);
    idle(3);

    // same-register arrival order
    cyc(0, 0, 0, 1, 5, 32'hB, 0);
    cyc(1, 5, 32'hA, 0, 0, 0, 0);
    #2;
    chk("t4_first", WD3, 32'hB);
    cyc(0, 0, 0, 0, 0, 0, 0);
    #2;
    chk("t4_second", WD3, 32'hA);
    chk("t4_a3", A3, 5);
    idle(2);

    // forwarding: B slot R7=0x77 behind output register R7=0x70
    cyc(0, 0, 0, 1, 7, 32'h70, 0);
    cyc(0, 0, 0, 1, 7, 32'h77, 0);
    #2;
    B_Valid = 0; FwdAddr = 7;
    #1;
`ifdef WRF_FWD_EN
    chk("t6_hit", FwdHit, 1);
    chk("t6_data", FwdData, 32'h77);
`else
    chk("t6_hit", FwdHit, 0);
    chk("t6_data", FwdData, 0);
`endif
    idle(3);

    // illegal index
    cyc(1, 15, 32'h1, 0, 0, 0, 15);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 0, 0, 0, 15);
      #2;
      chk("t5_we3", WE3, 0);
      chk("t5_err", ErrAddr, 1);
    end

    do_reset();
    for (int i = 0; i < 2000; i++)
      cyc(1'($urandom_range(0, 3) != 0), raddr(), $urandom,
          1'($urandom_range(0, 3) != 0), raddr(), $urandom, raddr());
    // reset in the middle of traffic
    do_reset();
    for (int i = 0; i < 500; i++)
      cyc(1'($urandom), raddr(), $urandom, 1'($urandom), raddr(), $urandom, raddr());
    idle(4);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
